// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared types and March C- element descriptors for the
//                march_sequencer BIST controller.
//                Descriptor vectors are indexed by element number (bit e
//                describes element e). Bits 6 and 7 are padding, so that a
//                3-bit element index can never select outside the vector.
//  Revision    : 1.0  initial release
// ============================================================================
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int         MARCH_LEN = 6;
    localparam logic [2:0] LAST_ELEM = 3'(MARCH_LEN - 1);

    // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
    localparam logic [7:0] ELEM_DOWN      = 8'b0001_1000;
    localparam logic [7:0] ELEM_HAS_READ  = 8'b0011_1110;
    localparam logic [7:0] ELEM_RD_VAL    = 8'b0001_0100;  // 1 = expect all ones
    localparam logic [7:0] ELEM_HAS_WRITE = 8'b0001_1111;
    localparam logic [7:0] ELEM_WR_VAL    = 8'b0000_1010;  // 1 = write all ones

    function automatic logic is_last_elem(input logic [2:0] e);
        return e == LAST_ELEM;
    endfunction

endpackage
`default_nettype wire

// File: rtl/march_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : march_sequencer_if
//  Description : Memory-side bus between the BIST sequencer and the memory.
//                master : sequencer (drives address, data, strobes)
//                slave  : memory    (returns read data one cycle after mem_rd)
//  Signals     : mem_addr, mem_din, mem_wr, mem_rd, mem_dout
//  Revision    : 1.0  initial release
// ============================================================================
interface march_sequencer_if #(
    parameter int DATA_WIDTH = 4,
    parameter int AD_WIDTH   = 4
) ();
    logic [AD_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (output mem_addr, output mem_din, output mem_wr,
                    output mem_rd, input mem_dout);
    modport slave  (input mem_addr, input mem_din, input mem_wr,
                    input mem_rd, output mem_dout);
endinterface
`default_nettype wire

// File: rtl/march_addr_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : march_addr_cnt
//  Description : Up/down address counter for one March element.
//                load  : latch direction, go to first address (0 or N-1)
//                step  : advance one address in the latched direction
//                last  : current address is the terminal one for the element
//  Ports       : clk, rst, load, load_down, step -> addr, last
//  Revision    : 1.0  initial release
// ============================================================================
module march_addr_cnt #(
    parameter int AD_WIDTH = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                load,
    input  wire logic                load_down,
    input  wire logic                step,
    output logic [AD_WIDTH-1:0]      addr,
    output logic                     last
);
    logic [AD_WIDTH-1:0] r_addr;
    logic                r_down;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_down <= 1'b0;
        end else if (load) begin
            r_down <= load_down;
            r_addr <= load_down ? '1 : '0;
        end else if (step) begin
            r_addr <= r_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
        end
    end

    // The terminal compare is the only exit; the sequencer never steps past it.
    assign last = r_down ? (r_addr == '0) : (r_addr == '1);
    assign addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/march_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : march_sequencer
//  Description : March C- BIST controller. Drives the memory directly,
//                compares read data against the element background and
//                reports pass/fail, first-failure address/element and a
//                saturating error count.
//  Ports       : clk, rst, start, stop_on_fail        control
//                mem (march_sequencer_if.master)      memory bus
//                busy, done, fail, fail_addr,
//                fail_elem, err_count                 status
//  Revision    : 1.0  initial release
// ============================================================================
module march_sequencer
    import bist_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int AD_WIDTH      = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic                  stop_on_fail,
    march_sequencer_if.master          mem,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [AD_WIDTH-1:0]        fail_addr,
    output logic [2:0]                 fail_elem,
    output logic [ERR_CNT_WIDTH-1:0]   err_count
);
    state_t                   r_state, w_next;
    logic [2:0]               r_elem;
    logic                     r_stop;
    logic                     r_fail;
    logic [ERR_CNT_WIDTH-1:0] r_err;
    logic [AD_WIDTH-1:0]      r_faddr;
    logic [2:0]               r_felem;

    logic                     w_start, w_load, w_load_down, w_step;
    logic                     w_wr, w_rd, w_mismatch;
    logic [DATA_WIDTH-1:0]    w_din, w_exp;
    logic [2:0]               w_elem_nxt;
    logic [AD_WIDTH-1:0]      w_addr;
    logic                     w_last;

    march_addr_cnt #(.AD_WIDTH(AD_WIDTH)) u_addr_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_down (w_load_down),
        .step      (w_step),
        .addr      (w_addr),
        .last      (w_last)
    );

    assign w_elem_nxt = r_elem + 3'd1;
    assign w_exp      = {DATA_WIDTH{ELEM_RD_VAL[r_elem]}};

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_load_down = 1'b0;
        w_step      = 1'b0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_din       = '0;
        w_mismatch  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start = 1'b1;
                    w_load  = 1'b1;   // E0 is an up element
                    w_next  = S_WRITE;
                end
            end
            S_WRITE: begin
                w_wr  = 1'b1;
                w_din = {DATA_WIDTH{ELEM_WR_VAL[r_elem]}};
                if (w_last) w_next = S_NEXT;
                else        w_step = 1'b1;
            end
            S_READ: begin
                w_rd   = 1'b1;
                w_next = S_CHECK;
            end
            S_CHECK: begin
                // Read data arrives this cycle; the complement write shares it.
                w_mismatch = (mem.mem_dout != w_exp);
                if (w_mismatch && r_stop) begin
                    w_next = S_DONE;
                end else begin
                    w_wr  = ELEM_HAS_WRITE[r_elem];
                    w_din = w_wr ? {DATA_WIDTH{ELEM_WR_VAL[r_elem]}} : '0;
                    if (w_last) begin
                        w_next = is_last_elem(r_elem) ? S_DONE : S_NEXT;
                    end else begin
                        w_step = 1'b1;
                        w_next = S_READ;
                    end
                end
            end
            S_NEXT: begin
                w_load      = 1'b1;
                w_load_down = ELEM_DOWN[w_elem_nxt];
                w_next      = ELEM_HAS_READ[w_elem_nxt] ? S_READ : S_WRITE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_elem  <= '0;
            r_stop  <= 1'b0;
            r_fail  <= 1'b0;
            r_err   <= '0;
            r_faddr <= '0;
            r_felem <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_elem  <= '0;
                r_stop  <= stop_on_fail;
                r_fail  <= 1'b0;
                r_err   <= '0;
                r_faddr <= '0;
                r_felem <= '0;
            end else begin
                if (r_state == S_NEXT) r_elem <= w_elem_nxt;
                if (w_mismatch) begin
                    r_fail <= 1'b1;
                    if (r_err != '1) r_err <= r_err + 1'b1;
                    if (!r_fail) begin
                        r_faddr <= w_addr;
                        r_felem <= r_elem;
                    end
                end
            end
        end
    end

    assign mem.mem_addr = w_addr;
    assign mem.mem_din  = w_din;
    assign mem.mem_wr   = w_wr;
    assign mem.mem_rd   = w_rd;

    assign busy      = (r_state == S_WRITE) || (r_state == S_READ) ||
                       (r_state == S_CHECK) || (r_state == S_NEXT);
    assign done      = (r_state == S_DONE);
    assign fail      = r_fail;
    assign fail_addr = r_faddr;
    assign fail_elem = r_felem;
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_march_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_march_sequencer
//  Description : Bench for march_sequencer with a 16x4 memory model that can
//                hold bit0 of address 5 stuck at 1. Each test run pushes its
//                expected result record; the monitor pops it when done rises
//                and compares latency, status and strobe counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_march_sequencer;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int EW = 8;

    typedef struct {
        int lat;
        int fail;
        int err;
        int faddr;
        int felem;
        int nwr;
        int nrd;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, stop_on_fail, fault_en;
    logic busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [EW-1:0] err_count;

    logic [DW-1:0] mem_raw [16];
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int n_done = 0;

    march_sequencer_if #(.DATA_WIDTH(DW), .AD_WIDTH(AW)) mem_bus ();

    march_sequencer #(.DATA_WIDTH(DW), .AD_WIDTH(AW), .ERR_CNT_WIDTH(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop_on_fail (stop_on_fail),
        .mem          (mem_bus),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .fail_addr    (fail_addr),
        .fail_elem    (fail_elem),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write at the edge, read data valid next cycle.
    initial begin
        for (int i = 0; i < 16; i++) mem_raw[i] = '0;
        mem_bus.mem_dout = '0;
        forever begin
            @(posedge clk);
            if (mem_bus.mem_wr) mem_raw[mem_bus.mem_addr] <= mem_bus.mem_din;
            if (mem_bus.mem_rd)
                mem_bus.mem_dout <= mem_raw[mem_bus.mem_addr] |
                    ((fault_en && mem_bus.mem_addr == 4'd5) ? 4'b0001 : 4'b0000);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        int cyc = 0, t_busy = 0, nwr = 0, nrd = 0;
        logic busy_q = 1'b0, done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !busy_q) begin
                t_busy = cyc;
                nwr = 0;
                nrd = 0;
            end
            if (busy) begin
                nwr += int'(mem_bus.mem_wr);
                nrd += int'(mem_bus.mem_rd);
            end
            if (mem_bus.mem_wr && mem_bus.mem_rd) chk("wr_rd_overlap", 1, 0);
            if (mem_bus.mem_wr && !busy) chk("wr_while_idle", 1, 0);
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency",   cyc - t_busy,    e.lat);
                    chk("fail",      int'(fail),      e.fail);
                    chk("err_count", int'(err_count), e.err);
                    chk("fail_addr", int'(fail_addr), e.faddr);
                    chk("fail_elem", int'(fail_elem), e.felem);
                    chk("wr_count",  nwr,             e.nwr);
                    chk("rd_count",  nrd,             e.nrd);
                end
                n_done++;
            end
            busy_q = busy;
            done_q = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0 = n_done;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done != n0) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},   int'(busy),             0);
        chk({tag, "_done"},   int'(done),             0);
        chk({tag, "_fail"},   int'(fail),             0);
        chk({tag, "_err"},    int'(err_count),        0);
        chk({tag, "_faddr"},  int'(fail_addr),        0);
        chk({tag, "_felem"},  int'(fail_elem),        0);
        chk({tag, "_wr"},     int'(mem_bus.mem_wr),   0);
        chk({tag, "_rd"},     int'(mem_bus.mem_rd),   0);
        chk({tag, "_addr"},   int'(mem_bus.mem_addr), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop_on_fail = 1'b0; fault_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("reset");

        // Clean run
        sb.push_back('{181, 0, 0, 0, 0, 80, 80});
        pulse_start();
        wait_done(400);

        // Stuck-at-1 bit0 @5: mismatches in E1, E3, E5
        fault_en = 1'b1;
        sb.push_back('{181, 1, 3, 5, 1, 80, 80});
        pulse_start();
        wait_done(400);

        // Same fault, abort at E1 CHECK of address 5 (busy offset 28)
        stop_on_fail = 1'b1;
        sb.push_back('{29, 1, 1, 5, 1, 21, 6});
        pulse_start();
        stop_on_fail = 1'b0;
        wait_done(400);
        chk("addr5_not_written", int'(mem_raw[5]), 0);
        chk("addr4_written",     int'(mem_raw[4]), 15);

        // start re-asserted while busy is ignored
        sb.push_back('{181, 1, 3, 5, 1, 80, 80});
        pulse_start();
        repeat (50) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(400);

        // Restart from failing DONE with the fault removed
        fault_en = 1'b0;
        sb.push_back('{181, 0, 0, 0, 0, 80, 80});
        pulse_start();
        chk("restart_fail",  int'(fail),      0);
        chk("restart_err",   int'(err_count), 0);
        chk("restart_faddr", int'(fail_addr), 0);
        chk("restart_felem", int'(fail_elem), 0);
        chk("restart_busy",  int'(busy),      1);
        wait_done(400);

        // Reset in E3: busy offset 89 is READ of address 12
        fault_en = 1'b1;
        pulse_start();
        repeat (89) @(negedge clk);
        chk("e3_rd",   int'(mem_bus.mem_rd),   1);
        chk("e3_addr", int'(mem_bus.mem_addr), 12);
        chk("e3_fail", int'(fail),             1);
        chk("e3_err",  int'(err_count),        1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("midrst");
        repeat (5) @(negedge clk);
        fault_en = 1'b0;
        sb.push_back('{181, 0, 0, 0, 0, 80, 80});
        pulse_start();
        wait_done(400);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
